// File: rtl/sdram_req_fifo_if.sv
// sdram_req_fifo_if: user request, controller and read-response signals of sdram_req_fifo.
interface sdram_req_fifo_if #(
    parameter int AddrWidth = 22,
    parameter int DataWidth = 16,
    parameter int Depth     = 8
);
    logic                     i_req_valid;
    logic                     o_req_ready;
    logic                     i_req_we;
    logic [AddrWidth-1:0]     i_req_addr;
    logic [DataWidth-1:0]     i_req_data;
    logic                     o_ctrl_wr_req;
    logic                     o_ctrl_rd_req;
    logic [AddrWidth-1:0]     o_ctrl_addr;
    logic [DataWidth-1:0]     o_ctrl_wr_data;
    logic                     i_ctrl_ack;
    logic                     i_ctrl_rd_rdy;
    logic [DataWidth-1:0]     i_ctrl_rd_data;
    logic                     o_rsp_valid;
    logic [DataWidth-1:0]     o_rsp_data;
    logic                     i_rsp_ready;
    logic [$clog2(Depth):0]   o_level;

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_data,
        output i_ctrl_ack, i_ctrl_rd_rdy, i_ctrl_rd_data, i_rsp_ready,
        input  o_req_ready, o_ctrl_wr_req, o_ctrl_rd_req, o_ctrl_addr, o_ctrl_wr_data,
        input  o_rsp_valid, o_rsp_data, o_level
    );
    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_data,
        input  i_ctrl_ack, i_ctrl_rd_rdy, i_ctrl_rd_data, i_rsp_ready,
        output o_req_ready, o_ctrl_wr_req, o_ctrl_rd_req, o_ctrl_addr, o_ctrl_wr_data,
        output o_rsp_valid, o_rsp_data, o_level
    );
endinterface

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo: in-order request queue issuing one SDRAM request at a time,
// with a single-entry read-response register.
module sdram_req_fifo #(
    parameter int AddrWidth = 22,
    parameter int DataWidth = 16,
    parameter int Depth     = 8
) (
    input logic             i_dram_clk,
    input logic             i_rst_n,
    sdram_req_fifo_if.slave bus
);
    localparam int PtrW = $clog2(Depth);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t               r_state, w_next;
    logic [PtrW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [PtrW:0]        r_level;
    logic                 r_we_mem   [Depth];
    logic [AddrWidth-1:0] r_addr_mem [Depth];
    logic [DataWidth-1:0] r_data_mem [Depth];
    logic                 r_rsp_valid;
    logic [DataWidth-1:0] r_rsp_data;
    logic                 w_push, w_pop, w_head_we, w_issue;

    assign w_head_we          = r_we_mem[r_rd_ptr];
    assign w_issue            = r_state == ISSUE;
    assign bus.o_req_ready    = r_level != (PtrW+1)'(Depth);
    assign w_push             = bus.i_req_valid && bus.o_req_ready;
    assign w_pop              = w_issue && bus.i_ctrl_ack;
    assign bus.o_level        = r_level;
    assign bus.o_ctrl_wr_req  = w_issue && w_head_we;
    assign bus.o_ctrl_rd_req  = w_issue && !w_head_we;
    assign bus.o_ctrl_addr    = w_issue ? r_addr_mem[r_rd_ptr] : '0;
    assign bus.o_ctrl_wr_data = w_issue ? r_data_mem[r_rd_ptr] : '0;
    assign bus.o_rsp_valid    = r_rsp_valid;
    assign bus.o_rsp_data     = r_rsp_data;

    always_ff @(posedge i_dram_clk) begin
        if (w_push) begin
            r_we_mem[r_wr_ptr]   <= bus.i_req_we;
            r_addr_mem[r_wr_ptr] <= bus.i_req_addr;
            r_data_mem[r_wr_ptr] <= bus.i_req_data;
        end
    end

    always_ff @(posedge i_dram_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
            if (w_push && !w_pop) r_level <= r_level + (PtrW+1)'(1);
            else if (!w_push && w_pop) r_level <= r_level - (PtrW+1)'(1);
            if (r_state == WAIT_RD && bus.i_ctrl_rd_rdy) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= bus.i_ctrl_rd_data;
            end else if (bus.i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // A read waits in IDLE while a response is pending, so the response register is never overwritten.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_level != '0 && (w_head_we || !r_rsp_valid)) w_next = ISSUE;
            ISSUE:   if (bus.i_ctrl_ack) w_next = w_head_we ? IDLE : WAIT_RD;
            WAIT_RD: if (bus.i_ctrl_rd_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sdram_req_fifo.sv
// tb_sdram_req_fifo: directed checks of queueing, issue handshake, read response and reset.
module tb_sdram_req_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    sdram_req_fifo_if #(.AddrWidth(22), .DataWidth(16), .Depth(8)) bus ();

    sdram_req_fifo #(.AddrWidth(22), .DataWidth(16), .Depth(8)) dut (
        .i_dram_clk(clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [21:0] addr, input logic [15:0] data);
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = we;
        bus.i_req_addr  = addr;
        bus.i_req_data  = data;
        tick();
        bus.i_req_valid = 1'b0;
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        while (!(bus.o_ctrl_wr_req || bus.o_ctrl_rd_req) && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 10), 32'd1);
    endtask

    task automatic ack();
        bus.i_ctrl_ack = 1'b1;
        tick();
        bus.i_ctrl_ack = 1'b0;
    endtask

    task automatic rd_rdy(input logic [15:0] data);
        bus.i_ctrl_rd_rdy  = 1'b1;
        bus.i_ctrl_rd_data = data;
        tick();
        bus.i_ctrl_rd_rdy  = 1'b0;
    endtask

    task automatic rsp_take();
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_level"}, 32'(bus.o_level), 32'd0);
        chk({tag, "_ready"}, 32'(bus.o_req_ready), 32'd1);
        chk({tag, "_wr_req"}, 32'(bus.o_ctrl_wr_req), 32'd0);
        chk({tag, "_rd_req"}, 32'(bus.o_ctrl_rd_req), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(bus.o_rsp_data), 32'd0);
        chk({tag, "_addr"}, 32'(bus.o_ctrl_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(bus.o_ctrl_wr_data), 32'd0);
    endtask

    initial begin
        bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_addr = '0; bus.i_req_data = '0;
        bus.i_ctrl_ack = 1'b0; bus.i_ctrl_rd_rdy = 1'b0; bus.i_ctrl_rd_data = '0; bus.i_rsp_ready = 1'b0;
        #3;
        chk_reset_state("rst");
        #20 rst_n = 1'b1;
        tick();

        // single write, ack three cycles after the request appears
        push(1'b1, 22'h00123, 16'hBEEF);
        chk("wr_level1", 32'(bus.o_level), 32'd1);
        chk("wr_req_not_yet", 32'(bus.o_ctrl_wr_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_req_high", 32'(bus.o_ctrl_wr_req), 32'd1);
            chk("wr_rd_req_low", 32'(bus.o_ctrl_rd_req), 32'd0);
            chk("wr_addr", 32'(bus.o_ctrl_addr), 32'h00123);
            chk("wr_data", 32'(bus.o_ctrl_wr_data), 32'hBEEF);
        end
        ack();
        chk("wr_req_done", 32'(bus.o_ctrl_wr_req), 32'd0);
        chk("wr_level0", 32'(bus.o_level), 32'd0);

        // single read with response held until consumed; stray strobes ignored
        rd_rdy(16'h1234);
        chk("stray_rdy_ignored", 32'(bus.o_rsp_valid), 32'd0);
        push(1'b0, 22'h3FFFFF, 16'h0);
        tick();
        chk("rd_req_high", 32'(bus.o_ctrl_rd_req), 32'd1);
        chk("rd_addr", 32'(bus.o_ctrl_addr), 32'h3FFFFF);
        ack();
        chk("rd_req_done", 32'(bus.o_ctrl_rd_req), 32'd0);
        chk("rd_no_rsp_yet", 32'(bus.o_rsp_valid), 32'd0);
        rd_rdy(16'hA5A5);
        chk("rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
        chk("rsp_data", 32'(bus.o_rsp_data), 32'hA5A5);
        tick(); tick();
        chk("rsp_valid_hold", 32'(bus.o_rsp_valid), 32'd1);
        chk("rsp_data_hold", 32'(bus.o_rsp_data), 32'hA5A5);
        rsp_take();
        chk("rsp_cleared", 32'(bus.o_rsp_valid), 32'd0);

        // fill to full, push+ack while full, then refill across the wrap and drain in order
        for (int i = 0; i < 8; i++) push(1'b1, 22'(32'h10 + i), 16'(32'h1000 + i));
        chk("full_level", 32'(bus.o_level), 32'd8);
        chk("full_ready", 32'(bus.o_req_ready), 32'd0);
        bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_addr = 22'h77; bus.i_req_data = 16'h7777;
        bus.i_ctrl_ack = 1'b1;
        tick();
        bus.i_req_valid = 1'b0; bus.i_ctrl_ack = 1'b0;
        chk("full_pop_level", 32'(bus.o_level), 32'd7);
        chk("full_pop_ready", 32'(bus.o_req_ready), 32'd1);
        push(1'b1, 22'h99, 16'h9999);
        chk("wrap_level", 32'(bus.o_level), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            wait_issue("wrap_issue");
            chk("wrap_addr", 32'(bus.o_ctrl_addr), i < 8 ? 32'h10 + i : 32'h99);
            chk("wrap_data", 32'(bus.o_ctrl_wr_data), i < 8 ? 32'h1000 + i : 32'h9999);
            ack();
        end
        chk("wrap_empty", 32'(bus.o_level), 32'd0);

        // second read and a write behind it stall until the response is taken
        push(1'b0, 22'h100, 16'h0);
        push(1'b0, 22'h200, 16'h0);
        push(1'b1, 22'h300, 16'h3333);
        wait_issue("rr_issue1");
        chk("rr_addr1", 32'(bus.o_ctrl_addr), 32'h100);
        ack();
        rd_rdy(16'h1111);
        chk("rr_rsp1", 32'(bus.o_rsp_data), 32'h1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_blocked_rd", 32'(bus.o_ctrl_rd_req), 32'd0);
            chk("rr_blocked_wr", 32'(bus.o_ctrl_wr_req), 32'd0);
            chk("rr_blocked_level", 32'(bus.o_level), 32'd2);
        end
        rsp_take();
        chk("rr_still_idle", 32'(bus.o_ctrl_rd_req), 32'd0);
        tick();
        chk("rr_issue2", 32'(bus.o_ctrl_rd_req), 32'd1);
        chk("rr_addr2", 32'(bus.o_ctrl_addr), 32'h200);
        ack();
        rd_rdy(16'h2222);
        chk("rr_rsp2", 32'(bus.o_rsp_data), 32'h2222);
        wait_issue("rr_issue3");
        chk("rr_wr3", 32'(bus.o_ctrl_wr_req), 32'd1);
        chk("rr_addr3", 32'(bus.o_ctrl_addr), 32'h300);
        ack();
        rsp_take();

        // reset in WAIT_RD with a queued entry, then a late read strobe
        push(1'b0, 22'h155, 16'h0);
        push(1'b1, 22'h166, 16'h6666);
        wait_issue("mr_issue");
        ack();
        rst_n = 1'b0;
        #1;
        chk_reset_state("mr_rst");
        #2 rst_n = 1'b1;
        rd_rdy(16'hDEAD);
        chk_reset_state("mr_late");
        tick(); tick();
        chk_reset_state("mr_after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sdram_req_fifo.md
SDRAM_REQ_FIFO -- requirements
Module: sdram_req_fifo

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 22, meaning the user/controller address width, ordered {row, col, bank}.
REQ-002 The block SHALL have parameter DataWidth, default 16, meaning the data word width.
REQ-003 The block SHALL have parameter Depth, default 8 (power of two, >=2), meaning the number of request FIFO entries.
REQ-004 The block SHALL have port i_dram_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have ports i_req_valid, input, 1 and o_req_ready, output, 1: the user request handshake.
REQ-007 The block SHALL have ports i_req_we, input, 1 (1=write, 0=read), i_req_addr, input, AddrWidth, and i_req_data, input, DataWidth (used for writes only).
REQ-008 The block SHALL have ports o_ctrl_wr_req, output, 1 and o_ctrl_rd_req, output, 1: level requests to the SDRAM controller.
REQ-009 The block SHALL have ports o_ctrl_addr, output, AddrWidth and o_ctrl_wr_data, output, DataWidth: the head-entry fields.
REQ-010 The block SHALL have port i_ctrl_ack, input, 1: a one-cycle pulse from the controller meaning the current request was accepted.
REQ-011 The block SHALL have ports i_ctrl_rd_rdy, input, 1 and i_ctrl_rd_data, input, DataWidth: the controller read-sample strobe and its data.
REQ-012 The block SHALL have ports o_rsp_valid, output, 1, o_rsp_data, output, DataWidth, and i_rsp_ready, input, 1: the read-response handshake.
REQ-013 The block SHALL have port o_level, output, $clog2(Depth)+1: the current FIFO occupancy.

Function
REQ-014 A push SHALL occur on an edge with i_req_valid && o_req_ready, storing {we, addr, data}; o_req_ready = (o_level != Depth), independent of a same-cycle pop.
REQ-015 The FIFO SHALL be in order, with wrapping read/write pointers; a simultaneous push and pop SHALL leave o_level unchanged.
REQ-016 The FSM SHALL have states IDLE, ISSUE, and WAIT_RD.
REQ-017 IDLE SHALL move to ISSUE when o_level != 0 and (head.we == 1 or o_rsp_valid == 0); otherwise it SHALL stay in IDLE.
REQ-018 In ISSUE, o_ctrl_wr_req = head.we and o_ctrl_rd_req = !head.we.
REQ-019 In ISSUE, o_ctrl_addr and o_ctrl_wr_data SHALL equal the head entry and SHALL be held stable until i_ctrl_ack.
REQ-020 In all other states, o_ctrl_wr_req and o_ctrl_rd_req SHALL be 0.
REQ-021 ISSUE with i_ctrl_ack SHALL pop the head and go to IDLE if it was a write, or to WAIT_RD if it was a read; ISSUE without i_ctrl_ack SHALL stay in ISSUE.
REQ-022 WAIT_RD with i_ctrl_rd_rdy SHALL load i_ctrl_rd_data into o_rsp_data, set o_rsp_valid, and go to IDLE.
REQ-023 i_ctrl_ack outside ISSUE and i_ctrl_rd_rdy outside WAIT_RD SHALL be ignored.
REQ-024 o_rsp_valid SHALL clear on an edge with i_rsp_ready; o_rsp_data SHALL hold while o_rsp_valid=1; a read is never issued while o_rsp_valid=1, so the response is never overwritten.
REQ-025 Latency: a push into an empty FIFO at edge N SHALL raise the ctrl request after edge N+1; each completed request returns to IDLE, so consecutive issues are separated by at least one idle cycle.
REQ-026 Writes queued behind a blocked read SHALL stay blocked (no reordering).

Reset
REQ-027 When i_rst_n is low, asynchronously: state=IDLE, both pointers=0, o_level=0, o_req_ready=1, o_ctrl_wr_req=0, o_ctrl_rd_req=0, o_rsp_valid=0, o_rsp_data=0, o_ctrl_addr=0, o_ctrl_wr_data=0.
REQ-028 A reset asserted mid-operation, including during ISSUE or WAIT_RD, SHALL discard all queued entries and any pending response; a late i_ctrl_rd_rdy after release SHALL be ignored.

Verification
REQ-029 Push write {addr=0x00123, data=0xBEEF}, ack 3 cycles later -> o_ctrl_wr_req high from the edge after the push until the ack edge, with addr and data stable; o_level goes 1->0.
REQ-030 Push read addr=0x3FFFFF, ack, then rd_rdy with data 0xA5A5 -> o_rsp_valid=1 and o_rsp_data=0xA5A5, held until i_rsp_ready.
REQ-031 Push 8 entries with no ack -> o_level=8, o_req_ready=0; push+ack in the same cycle when full -> push rejected, level=7; fill across the pointer wrap -> FIFO order preserved.
REQ-032 Two reads queued, response not consumed -> the second o_ctrl_rd_req stays 0 until i_rsp_ready, then issues.
REQ-033 Reset asserted in WAIT_RD, then rd_rdy pulsed after release -> all outputs at reset values, o_rsp_valid stays 0.
